// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard controls, EXE redirect, instruction-memory port,
// IF/ID register outputs and the fetch performance counters.
interface if_stage_if #(
  parameter int IM_ADDR_W = 8
);
  logic                 flushF;
  logic                 bubbleF;
  logic                 flushD;
  logic                 bubbleD;
  logic                 br_taken_exe;
  logic [31:0]          br_target_exe;
  logic [IM_ADDR_W-1:0] im_addr;
  logic [31:0]          im_rdata;
  logic [31:0]          pc_if;
  logic [31:0]          pc_id;
  logic [31:0]          pc4_id;
  logic [31:0]          instr_id;
  logic                 valid_id;
  logic [31:0]          fetch_cnt;
  logic [31:0]          stall_cnt;
  logic [31:0]          flush_cnt;

  modport master (
    output flushF, bubbleF, flushD, bubbleD, br_taken_exe, br_target_exe, im_rdata,
    input  im_addr, pc_if, pc_id, pc4_id, instr_id, valid_id,
           fetch_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  flushF, bubbleF, flushD, bubbleD, br_taken_exe, br_target_exe, im_rdata,
    output im_addr, pc_if, pc_id, pc4_id, instr_id, valid_id,
           fetch_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing,
// IF/ID pipeline register and saturating fetch/stall/flush counters.
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int          IM_ADDR_W = 8,
  // Saturation ceiling of the counters; lowered only to exercise saturation quickly.
  parameter logic [31:0] CNT_MAX   = 32'hFFFF_FFFF
) (
  input logic      clk,
  input logic      rst,
  if_stage_if.slave bus
);

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    sat_inc = (cnt >= CNT_MAX) ? cnt : cnt + 32'd1;
  endfunction

  logic [31:0] pc_p0;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic [31:0] instr_p1;
  logic        vld_p1;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] pc_next4;
  logic        load_id;

  assign pc_next4 = pc_p0 + 32'd4;
  assign load_id  = !bus.flushD && !bus.bubbleD;

  // IF stage: PC register; a taken branch overrides bubbleF since the stalled fetch is squashed
  always_ff @(posedge clk) begin
    if (rst || bus.flushF) begin
      pc_p0 <= PC_RESET;
    end else if (bus.br_taken_exe) begin
      pc_p0 <= {bus.br_target_exe[31:2], 2'b00};
    end else if (!bus.bubbleF) begin
      pc_p0 <= pc_next4;
    end
  end

  // IF/ID boundary: flush inserts a NOP, bubble holds, otherwise capture the fetch
  always_ff @(posedge clk) begin
    if (rst || bus.flushD) begin
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (!bus.bubbleD) begin
      instr_p1 <= bus.im_rdata;
      pc_p1    <= pc_p0;
      pc4_p1   <= pc_next4;
      vld_p1   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (load_id)                      fetch_cnt <= sat_inc(fetch_cnt);
      if (bus.bubbleD && !bus.flushD)   stall_cnt <= sat_inc(stall_cnt);
      if (bus.flushD)                   flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.im_addr   = pc_p0[IM_ADDR_W+1:2];
  assign bus.pc_if     = pc_p0;
  assign bus.pc_id     = pc_p1;
  assign bus.pc4_id    = pc4_p1;
  assign bus.instr_id  = instr_p1;
  assign bus.valid_id  = vld_p1;
  assign bus.fetch_cnt = fetch_cnt;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule
